// File: rtl/instruction_fetch_unit.sv
// Purpose: fetch stage feeding IF/ID. Runs one instruction per cycle on
//          zero-wait memory, tolerates wait states, decode stalls and
//          branch redirects (redirects take priority over stalls).
// Latency: one cycle from a completed fetch to IF/ID. A fetch that completes
//          during a stall parks in a one-entry skid buffer, so no word is
//          lost or duplicated.
// Ports:   CLK, RESET (sync, active-high); stall, branch_taken, branch_target
//          from hazard/branch logic; imem_read/imem_addr/imem_rdata/imem_busy
//          to instruction memory; if_* is the IF/ID register; fetch_busy is
//          high while a fetch is outstanding (WAIT or DRAIN).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busy,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,  // issuing one fetch per cycle
    S_WAIT  = 2'd1,  // memory busy, request held on the same address
    S_HOLD  = 2'd2,  // fetched word parked in the skid buffer, decode stalled
    S_DRAIN = 2'd3   // redirected while busy: finish and discard old fetch
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic [31:0] saved_target;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;
  logic        fetch_done;

  // Instructions are word aligned; the low address bits of a target are dropped.
  assign target_aligned = branch_target & ~32'd3;
  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 == 0.
  assign pc_plus4       = pc + 32'd4;
  assign fetch_done     = imem_read && !imem_busy;

  // The request address is always the PC: PC only advances on a completed
  // fetch, so it is stable through WAIT and DRAIN.
  assign imem_addr = pc;

  always_comb begin
    imem_read = 1'b0;
    case (state)
      S_RUN:   imem_read = !stall;
      S_WAIT:  imem_read = 1'b1;
      S_DRAIN: imem_read = 1'b1;
      default: imem_read = 1'b0;
    endcase
  end

  assign fetch_busy     = (state == S_WAIT) || (state == S_DRAIN);
  assign if_instruction = ifid_valid ? ifid_instr : NOP_INSTR;
  assign if_pc          = ifid_pc;
  assign if_pc_plus4    = ifid_pc + 32'd4;
  assign if_valid       = ifid_valid;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_RUN;
      pc           <= RESET_PC;
      ifid_instr   <= NOP_INSTR;
      ifid_pc      <= 32'd0;
      ifid_valid   <= 1'b0;
      skid_instr   <= NOP_INSTR;
      skid_pc      <= 32'd0;
      skid_valid   <= 1'b0;
      saved_target <= 32'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (branch_taken) begin
            // Anything returned this cycle belongs to the wrong path.
            pc         <= target_aligned;
            ifid_valid <= 1'b0;
            skid_valid <= 1'b0;
            state      <= S_RUN;
          end else if (stall) begin
            // No request issued; PC and IF/ID simply hold.
            state <= S_RUN;
          end else if (fetch_done) begin
            ifid_instr <= imem_rdata;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
            pc         <= pc_plus4;
          end else begin
            // Request accepted but memory busy. Decode is not stalled here,
            // so the current IF/ID entry is consumed this edge: bubble it.
            ifid_valid <= 1'b0;
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (branch_taken) begin
            ifid_valid <= 1'b0;
            if (!imem_busy) begin
              pc    <= target_aligned;
              state <= S_RUN;
            end else begin
              // Memory still owes us a word on the old address; remember
              // where to go once it has been drained.
              saved_target <= target_aligned;
              state        <= S_DRAIN;
            end
          end else if (!imem_busy) begin
            pc <= pc_plus4;
            if (stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              skid_valid <= 1'b1;
              state      <= S_HOLD;
            end else begin
              ifid_instr <= imem_rdata;
              ifid_pc    <= pc;
              ifid_valid <= 1'b1;
              state      <= S_RUN;
            end
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            pc         <= target_aligned;
            ifid_valid <= 1'b0;
            skid_valid <= 1'b0;
            state      <= S_RUN;
          end else if (!stall) begin
            ifid_instr <= skid_instr;
            ifid_pc    <= skid_pc;
            ifid_valid <= skid_valid;
            skid_valid <= 1'b0;
            state      <= S_RUN;
          end
        end

        S_DRAIN: begin
          if (!imem_busy) begin
            // Old word discarded. A redirect landing in the same cycle is the
            // newest one and wins over the saved target.
            pc    <= branch_taken ? target_aligned : saved_target;
            state <= S_RUN;
          end else if (branch_taken) begin
            saved_target <= target_aligned;
          end
        end

        default: begin
          state      <= S_RUN;
          ifid_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction presented when IF/ID is invalid (ADDI x0,x0,0).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hazard-unit hold request for PC and IF/ID.
REQ-007 branch_taken  in  1  redirect pulse from branch/jump resolution.
REQ-008 branch_target  in  32  redirect address.
REQ-009 imem_rdata  in  32  instruction word from instruction memory.
REQ-010 imem_busy  in  1  memory not ready; data valid when imem_read=1 and imem_busy=0.
REQ-011 imem_read  out  1  fetch request.
REQ-012 imem_addr  out  32  fetch address.
REQ-013 if_instruction  out  32  IF/ID instruction word, feeding the decode/control stage.
REQ-014 if_pc  out  32  IF/ID PC of if_instruction.
REQ-015 if_pc_plus4  out  32  if_pc + 4.
REQ-016 if_valid  out  1  IF/ID holds a real instruction.
REQ-017 fetch_busy  out  1  high in WAIT or DRAIN.

Function
REQ-018 States SHALL be RUN, WAIT, HOLD, DRAIN; a 32-bit PC, a one-entry skid buffer (word, PC, valid), and a saved-target register SHALL exist.
REQ-019 A fetch SHALL complete in any cycle with imem_read=1 and imem_busy=0; imem_addr SHALL stay stable while imem_read=1 and imem_busy=1.
REQ-020 RUN: imem_read = !stall, imem_addr = PC; completion with stall=0 -> IF/ID <= {imem_rdata, PC, valid=1}, PC <= PC+4, stay RUN (zero-bubble, one instruction per cycle).
REQ-021 RUN with imem_busy=1 and imem_read=1 -> WAIT; IF/ID valid cleared at that edge unless stall=1.
REQ-022 RUN with stall=1: imem_read=0, PC and IF/ID held.
REQ-023 WAIT: imem_read=1, address held; completion with stall=0 -> IF/ID load, PC+4, RUN; completion with stall=1 -> skid buffer load, PC+4, HOLD.
REQ-024 HOLD: imem_read=0, IF/ID held; when stall=0 -> IF/ID <= skid, skid cleared, RUN.
REQ-025 If stall=1 in any state, IF/ID and if_valid SHALL hold unchanged (unless redirect).
REQ-026 Redirect (branch_taken=1) SHALL have priority over stall in every state.
REQ-027 Redirect in RUN or HOLD: PC <= target, if_valid <= 0, skid cleared, next state RUN; no request issued in that cycle's completion is kept.
REQ-028 Redirect in WAIT with imem_busy=0: returned word discarded, PC <= target, if_valid <= 0, RUN.
REQ-029 Redirect in WAIT with imem_busy=1: saved target <= branch_target, if_valid <= 0, DRAIN.
REQ-030 DRAIN: imem_read=1 on old address; completion -> word discarded, PC <= saved target, RUN; a further redirect in DRAIN overwrites saved target.
REQ-031 branch_target[1:0] SHALL be forced to 2'b00 on load.
REQ-032 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-033 if_instruction SHALL equal NOP_INSTR whenever if_valid=0.

Reset
REQ-034 On RESET: PC=RESET_PC, state RUN, if_valid=0, if_pc=0, if_pc_plus4=4, skid invalid, saved target 0; outputs if_instruction=NOP_INSTR, imem_read=1 (if stall=0), imem_addr=RESET_PC, fetch_busy=0 in first post-reset cycle.
REQ-035 RESET asserted mid-WAIT or mid-DRAIN SHALL abandon the outstanding fetch and return to reset values next edge.

Verification
REQ-036 Zero-wait memory, no stall, 4 cycles after reset -> if_pc sequence 0,4,8,C, if_valid=1 from cycle 1.
REQ-037 imem_busy=1 for 3 cycles at addr 0x8 -> imem_addr stays 0x8, fetch_busy=1, if_valid=0 for those cycles, then if_pc=0x8.
REQ-038 stall=1 during WAIT at 0x10, completion, stall held 2 more cycles -> HOLD, IF/ID unchanged, then if_pc=0x10 one cycle after stall falls, no lost/duplicated word.
REQ-039 branch_taken=1, target 0x103 while busy at 0x20 -> DRAIN, word at 0x20 discarded, next imem_addr=0x100, if_valid=0 until 0x100 returns.
REQ-040 stall=1 and branch_taken=1 same cycle, target 0x40 -> if_valid=0 next edge, imem_addr=0x40; PC=0xFFFF_FFFC completes -> next imem_addr=0x0.
